// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a 2**FIFO_AW-word TX FIFO feeding a frame FSM.
// Frames are start bit, LSB-first data, optional parity bit, then 1 or 2 stop bits.
// Queued words go out back-to-back with no idle gap between frames.
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 38400,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [FIFO_AW:0]      level,
  output logic                  overflow,
  output logic                  line,
  output logic                  busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int unsigned DEPTH        = 2 ** FIFO_AW;
  localparam int unsigned STOP_CYCLES  = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W        = $clog2(STOP_CYCLES + 1);
  localparam int unsigned BIT_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   STOP_LAST = CNT_W'(STOP_CYCLES - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [FIFO_AW:0]   LEVEL_MAX = (FIFO_AW + 1)'(DEPTH);

  // Illegal parameter combinations stop elaboration.
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_buffered: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_buffered: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2 || (CLK_FREQ % BAUDRATE) != 0) begin : g_bad_baud
    $error("uart_tx_buffered: CLK_FREQ/BAUDRATE must be an integer >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  push, pop;

  logic [CNT_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic                  bit_end;
  logic                  line_next;

  // A write is only accepted while the FIFO is not full, even if a pop frees
  // a slot on the same edge.
  assign push = wr_en && !full;
  assign full = (level == LEVEL_MAX);
  assign head = mem[rd_ptr];
  assign busy = (state != IDLE) || (level != '0);

  // FIFO storage; no reset needed since occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, FIFO pop and line level for the current state.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    bit_end    = 1'b0;
    line_next  = 1'b1;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_next = 1'b0;
        bit_end   = (baud_cnt == BIT_LAST);
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        line_next = shift[0];
        bit_end   = (baud_cnt == BIT_LAST);
        if (bit_end && bit_cnt == DATA_LAST) begin
          state_next = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        line_next = par_bit;
        bit_end   = (baud_cnt == BIT_LAST);
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        line_next = 1'b1;
        bit_end   = (baud_cnt == STOP_LAST);
        if (bit_end) begin
          if (level != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Baud and data-bit counters; baud restarts at every bit boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Shift register and parity bit, loaded when a word leaves the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      shift   <= head;
      par_bit <= (PARITY == 1) ? ~^head : ^head;
    end else if (state == DATA && bit_end) begin
      shift <= shift >> 1;
    end
  end

  // Registered serial line, so it trails the FSM state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line <= 1'b1;
    end else begin
      line <= line_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four instances (8N1 with a 4-word FIFO, 8E1, 8O1, 8N2).
// Stimulus queues hand-written frame bit patterns; a monitor decodes each line.
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] we;
  logic [7:0] wd [4];
  logic [3:0] full_v, ovf_v, line_v, busy_v;
  logic [2:0] lvl0;
  logic [4:0] lvl1, lvl2, lvl3;

  uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .FIFO_AW(2),
                     .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[0]), .wr_data(wd[0]), .full(full_v[0]),
    .level(lvl0), .overflow(ovf_v[0]), .line(line_v[0]), .busy(busy_v[0]));
  uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .FIFO_AW(4),
                     .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[1]), .wr_data(wd[1]), .full(full_v[1]),
    .level(lvl1), .overflow(ovf_v[1]), .line(line_v[1]), .busy(busy_v[1]));
  uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .FIFO_AW(4),
                     .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[2]), .wr_data(wd[2]), .full(full_v[2]),
    .level(lvl2), .overflow(ovf_v[2]), .line(line_v[2]), .busy(busy_v[2]));
  uart_tx_buffered #(.CLK_FREQ(38400), .BAUDRATE(9600), .DATA_WIDTH(8), .FIFO_AW(4),
                     .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(we[3]), .wr_data(wd[3]), .full(full_v[3]),
    .level(lvl3), .overflow(ovf_v[3]), .line(line_v[3]), .busy(busy_v[3]));

  // Expected frame: bit 0 is the first bit on the line (start), then data LSB first,
  // parity if any, stop bit(s).
  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [10:0] frame;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;

  int   frames_done [4];
  bit   in_frame [4];
  sb_t  cur [4];
  int   pos_cyc [4];
  int   errs [4];
  int   first_pos [4];
  logic first_act [4];
  int   prev_start [4];
  int   gap [4];
  int   ncyc = 0;
  int   m_idx;
  int   m_bit;

  // Burst table for the 4-word FIFO instance (hand-derived).
  logic [7:0]  burst_d   [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  logic [10:0] burst_f   [7] = '{11'h222, 11'h244, 11'h266, 11'h288, 11'h2AA, 11'h2CC, 11'h2EE};
  logic [2:0]  burst_lvl [7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
  logic        burst_ful [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        burst_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic int frame_bits(int k);
    return (k == 0) ? 10 : 11;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one write cycle; queue the frame only if the write should be accepted.
  task automatic send(int k, logic [7:0] d, logic [10:0] f, bit accept);
    sb_t e;
    if (accept) begin
      e.dut   = k;
      e.data  = d;
      e.frame = f;
      sb.push_back(e);
    end
    we[k] = 1'b1;
    wd[k] = d;
    @(posedge clk);
    #1;
    we[k] = 1'b0;
  endtask

  task automatic wait_frames(int k, int n, int budget);
    int t = 0;
    while (frames_done[k] < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk($sformatf("frames_dut%0d", k), frames_done[k], n);
  endtask

  // Monitor: detect start bits, pop the matching expectation, compare every cycle.
  initial begin
    for (int k = 0; k < 4; k++) begin
      frames_done[k] = 0;
      in_frame[k]    = 1'b0;
      prev_start[k]  = 0;
      gap[k]         = 0;
    end
    forever begin
      @(negedge clk);
      ncyc++;
      for (int k = 0; k < 4; k++) begin
        if (rst_n !== 1'b1) begin
          in_frame[k] = 1'b0;
        end else if (!in_frame[k]) begin
          if (line_v[k] === 1'b0) begin
            m_idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (m_idx < 0 && sb[i].dut == k) m_idx = i;
            end
            if (m_idx < 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_start dut%0d: line=0 at cycle %0d, expected idle 1", k, ncyc);
              cur[k].dut   = k;
              cur[k].data  = 8'h00;
              cur[k].frame = 11'h7FE;
            end else begin
              cur[k] = sb[m_idx];
              sb.delete(m_idx);
            end
            in_frame[k]   = 1'b1;
            pos_cyc[k]    = 1;
            errs[k]       = 0;
            gap[k]        = ncyc - prev_start[k];
            prev_start[k] = ncyc;
          end
        end else begin
          m_bit = pos_cyc[k] / 4;
          if (line_v[k] !== cur[k].frame[m_bit]) begin
            if (errs[k] == 0) begin
              first_pos[k] = m_bit;
              first_act[k] = line_v[k];
            end
            errs[k]++;
          end
          pos_cyc[k]++;
          if (pos_cyc[k] == frame_bits(k) * 4) begin
            checks++;
            in_frame[k] = 1'b0;
            frames_done[k]++;
            if (errs[k] != 0) begin
              failures++;
              $display("FAIL frame dut%0d data=%02h: bit %0d line=%b expected %b (%0d bad cycles)",
                       k, cur[k].data, first_pos[k], first_act[k],
                       cur[k].frame[first_pos[k]], errs[k]);
            end
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int lowcnt;
    int t;
    rst_n = 1'b0;
    we    = '0;
    for (int k = 0; k < 4; k++) wd[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", line_v, 4'hF);
    chk("rst_busy", busy_v, 4'h0);
    chk("rst_full", full_v, 4'h0);
    chk("rst_ovf", ovf_v, 4'h0);
    chk("rst_lvl0", lvl0, 0);
    chk("rst_lvl1", lvl1, 0);
    chk("rst_lvl2", lvl2, 0);
    chk("rst_lvl3", lvl3, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8N1 0xA5: check first-word latency (line low from the second edge after the write).
    send(0, 8'hA5, 11'h34A, 1'b1);
    @(negedge clk);
    chk("lat_e0_line", line_v[0], 1);
    chk("lat_e0_level", lvl0, 1);
    chk("lat_e0_busy", busy_v[0], 1);
    @(negedge clk);
    chk("lat_e1_line", line_v[0], 1);
    chk("lat_e1_level", lvl0, 0);
    @(negedge clk);
    chk("lat_e2_line", line_v[0], 0);
    #1;

    // Parity variants, queued back-to-back.
    send(1, 8'hA5, 11'h54A, 1'b1);
    send(2, 8'hA5, 11'h74A, 1'b1);
    send(1, 8'h01, 11'h602, 1'b1);
    send(2, 8'h01, 11'h402, 1'b1);

    // 8N2 back-to-back: busy never drops, second start right after 8 stop cycles.
    send(3, 8'h00, 11'h600, 1'b1);
    send(3, 8'hFF, 11'h7FE, 1'b1);
    lowcnt = 0;
    t = 0;
    while (frames_done[3] < 2 && t < 400) begin
      @(negedge clk);
      #1;
      if (!busy_v[3] && frames_done[3] < 2) lowcnt++;
      t++;
    end
    chk("frames_dut3", frames_done[3], 2);
    chk("busy_low_mid", lowcnt, 0);
    chk("busy_after", busy_v[3], 0);
    chk("stop2_gap", gap[3], 44);

    wait_frames(0, 1, 200);
    wait_frames(1, 2, 300);
    wait_frames(2, 2, 300);

    // Burst of 7 writes into the idle 4-word FIFO: 5 accepted, 2 dropped.
    for (int i = 0; i < 7; i++) begin
      send(0, burst_d[i], burst_f[i], (i < 5));
      chk($sformatf("burst%0d_level", i), lvl0, burst_lvl[i]);
      chk($sformatf("burst%0d_full", i), full_v[0], burst_ful[i]);
      chk($sformatf("burst%0d_ovf", i), ovf_v[0], burst_ovf[i]);
    end
    // The first frame ends (and the next word pops) 41 edges after the first write.
    repeat (34) @(posedge clk);
    #1;
    chk("prepop_level", lvl0, 4);
    chk("prepop_ovf", ovf_v[0], 0);
    send(0, 8'h88, 11'h310, 1'b0);
    chk("fullpop_level", lvl0, 3);
    chk("fullpop_full", full_v[0], 0);
    chk("fullpop_ovf", ovf_v[0], 1);
    wait_frames(0, 6, 400);

    // Reset during data bit 3 aborts the frame and discards queued words.
    send(0, 8'h5A, 11'h2B4, 1'b1);
    send(0, 8'h66, 11'h2CC, 1'b0);
    send(0, 8'h77, 11'h2EE, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    chk("prerst_level", lvl0, 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_line", line_v[0], 1);
    chk("midrst_level", lvl0, 0);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_full", full_v[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'h3C, 11'h278, 1'b1);
    wait_frames(0, 7, 200);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
